fetch_sequencer: RTL
====================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter FLUSH_SLOTS, default 2, number of fetch slots squashed after a taken branch (legal 1..3).
REQ-002 SHALL have port clock  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port halt  input  1  stop fetching until reset.
REQ-005 SHALL have port branch_taken  input  1  EX-stage branch/jump resolved taken.
REQ-006 SHALL have port branch_offset  input  32  byte offset of taken branch, sampled when branch_taken=1.
REQ-007 SHALL have port hazard_stall  input  1  ID-stage load-use hazard request.
REQ-008 SHALL have port mem_wait  input  1  instruction-memory wait request.
REQ-009 SHALL have port succ  output  1  redirect command to program counter.
REQ-010 SHALL have port new_addr  output  32  redirect byte offset, valid when succ=1.
REQ-011 SHALL have port stall  output  1  hold command to program counter.
REQ-012 SHALL have port flush  output  1  squash IF/ID contents.
REQ-013 SHALL have port state  output  3  current FSM state encoding.
REQ-014 SHALL have port stall_cycles  output  16  saturating count of cycles with stall=1.

Function
REQ-015 SHALL implement FSM RUN=0, STALL=1, REDIRECT=2, FLUSH=3, HALT=4; other codes unreachable, decode to RUN.
REQ-016 SHALL register all outputs; each output reflects decision from inputs of previous edge (1-cycle latency).
REQ-017 SHALL apply input priority halt > branch_taken > (hazard_stall | mem_wait) > none in RUN and STALL.
REQ-018 RUN: halt -> HALT; branch_taken -> REDIRECT; stall request -> STALL; else stay RUN; outputs succ=0, stall=0, flush=0.
REQ-019 STALL: stall=1 while in state; request deasserted -> RUN; branch_taken -> REDIRECT (branch is older, stalled instruction squashed).
REQ-020 REDIRECT: exactly one cycle; succ=1, new_addr=branch_offset captured on entry edge, flush=1, stall=0; load flush_cnt=FLUSH_SLOTS-1; next FLUSH, or RUN if FLUSH_SLOTS=1.
REQ-021 FLUSH: flush=1, succ=0, stall=0; decrement flush_cnt each cycle; exit to RUN after cycle with flush_cnt=0.
REQ-022 FLUSH: branch_taken, hazard_stall, mem_wait ignored (originate from squashed slots); halt -> HALT immediately.
REQ-023 HALT: stall=1, succ=0, flush=0; absorbing until reset.
REQ-024 new_addr SHALL hold last captured value outside REDIRECT.
REQ-025 stall_cycles SHALL increment by 1 each cycle stall output is 1, saturating at 16'hFFFF, never wrapping.
REQ-026 Simultaneous branch_taken and stall request SHALL yield REDIRECT, no STALL cycle.

Reset
REQ-027 reset=0 SHALL asynchronously force state=RUN, succ=0, stall=0, flush=0, new_addr=0, flush_cnt=0, stall_cycles=0.
REQ-028 Reset asserted mid-REDIRECT/FLUSH/STALL SHALL abandon sequence; first edge after release evaluates inputs from RUN.

Structure
REQ-029 State encodings and FLUSH_SLOTS default SHALL live in shared package pipeline_pkg.
REQ-030 Saturating counter SHALL be one sub-module sat_counter (width parameter, enable, clear); FSM kept in fetch_sequencer.

Verification
REQ-031 Reset release, all inputs 0, 10 cycles -> state=RUN, succ=stall=flush=0, stall_cycles=0.
REQ-032 branch_taken=1, offset=32'h0000_0010 one cycle -> next cycle succ=1, new_addr=0x10, flush=1; then 1 FLUSH cycle (FLUSH_SLOTS=2); then RUN.
REQ-033 hazard_stall=1 for 3 cycles -> stall=1 for exactly 3 cycles starting 1 cycle later, stall_cycles=3.
REQ-034 hazard_stall and branch_taken both 1 same cycle -> REDIRECT next, stall never 1.
REQ-035 branch_taken=1 during FLUSH -> ignored, no second succ pulse; halt during FLUSH -> HALT, stall=1 held.
REQ-036 reset=0 pulsed mid-FLUSH -> outputs zero immediately (no clock edge), RUN after release; force 65540 stall cycles -> stall_cycles=0xFFFF.

Source files
------------

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared fetch-sequencer state encodings and defaults
package pipeline_pkg;

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_STALL    = 3'd1,
    ST_REDIRECT = 3'd2,
    ST_FLUSH    = 3'd3,
    ST_HALT     = 3'd4
  } fetch_state_e;

  localparam int unsigned FLUSH_SLOTS_DEFAULT = 2;
  localparam int unsigned STALL_CNT_W         = 16;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with enable and synchronous clear
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q, count_d;

  // Next count: clear wins, otherwise count up and stick at all-ones.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register with asynchronous clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetch redirect/stall/flush sequencer with registered outputs
module fetch_sequencer
  import pipeline_pkg::*;
#(
  parameter int unsigned FLUSH_SLOTS = FLUSH_SLOTS_DEFAULT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   halt,
  input  logic                   branch_taken,
  input  logic [31:0]            branch_offset,
  input  logic                   hazard_stall,
  input  logic                   mem_wait,
  output logic                   succ,
  output logic [31:0]            new_addr,
  output logic                   stall,
  output logic                   flush,
  output logic [2:0]             state,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  // Remaining squash cycles after REDIRECT; REDIRECT itself is the first squashed slot.
  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_SLOTS - 1);

  fetch_state_e state_q, state_d;
  logic [1:0]   flush_cnt_q, flush_cnt_d;
  logic         succ_q, succ_d;
  logic         stall_q, stall_d;
  logic         flush_q, flush_d;
  logic [31:0]  new_addr_q, new_addr_d;
  logic         stall_req;

  assign stall_req = hazard_stall | mem_wait;

  // Next-state decision and the output values that state will present.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    new_addr_d  = new_addr_q;
    case (state_q)
      ST_REDIRECT: begin
        if (flush_cnt_q == 2'd0) begin
          state_d = ST_RUN;
        end else begin
          state_d     = ST_FLUSH;
          flush_cnt_d = flush_cnt_q - 2'd1;
        end
      end
      ST_FLUSH: begin
        // Branch/stall requests here come from squashed slots and are dropped.
        if (halt) begin
          state_d = ST_HALT;
        end else if (flush_cnt_q == 2'd0) begin
          state_d = ST_RUN;
        end else begin
          flush_cnt_d = flush_cnt_q - 2'd1;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        // RUN, STALL and any unreachable code share one priority chain.
        if (halt) begin
          state_d = ST_HALT;
        end else if (branch_taken) begin
          state_d     = ST_REDIRECT;
          flush_cnt_d = FLUSH_LOAD;
          new_addr_d  = branch_offset;
        end else if (stall_req) begin
          state_d = ST_STALL;
        end else begin
          state_d = ST_RUN;
        end
      end
    endcase
    succ_d  = (state_d == ST_REDIRECT);
    stall_d = (state_d == ST_STALL) || (state_d == ST_HALT);
    flush_d = (state_d == ST_REDIRECT) || (state_d == ST_FLUSH);
  end

  // State and output registers; reset abandons any sequence in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= 2'd0;
      succ_q      <= 1'b0;
      stall_q     <= 1'b0;
      flush_q     <= 1'b0;
      new_addr_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      succ_q      <= succ_d;
      stall_q     <= stall_d;
      flush_q     <= flush_d;
      new_addr_q  <= new_addr_d;
    end
  end

  sat_counter #(
    .WIDTH (STALL_CNT_W)
  ) u_stall_counter (
    .clk_i   (clock),
    .rst_ni  (reset),
    .en_i    (stall_q),
    .clr_i   (1'b0),
    .count_o (stall_cycles)
  );

  assign succ     = succ_q;
  assign stall    = stall_q;
  assign flush    = flush_q;
  assign new_addr = new_addr_q;
  assign state    = state_q;

endmodule
